// File: rtl/prm_result_scan.sv
// -----------------------------------------------------------------------------
// prm_result_scan
//
// Sweeps the 128 x 32-bit windowed readout of the edge-check stage after a
// start request and accumulates a summary of the 4096 edge bits:
//   - hit_count     : population count of set bits (0..4096)
//   - any_hit       : at least one set bit seen
//   - first_hit_idx : global index (word*32 + bit) of the lowest set bit
// done pulses for one cycle when the sweep completes. The summary then holds
// until the next accepted start.
//
// For each word, the select outputs are held for SETTLE_CYC cycles so that
// the upstream 4096-to-32 combinational mux can settle. result_imp is then
// sampled for one cycle.
//
// Ports
//   CLK            in   1   clock
//   RST_n          in   1   synchronous active-low reset
//   start          in   1   scan request (pulse or level, accepted in IDLE)
//   result_imp     in  32   selected result word from upstream
//   sel1           out  3   bank select, word index [6:4]
//   sel2           out  8   word-in-bank select, {4'b0, word index [3:0]}
//   busy           out  1   scan in progress
//   done           out  1   one-cycle completion pulse
//   hit_count      out 13   number of set bits
//   any_hit        out  1   any set bit seen
//   first_hit_idx  out 12   index of lowest set bit, 0 when any_hit=0
//
// Optional build macro PRM_SCAN_ABORT_EN adds these ports:
//   abort          in   1   stop the scan from SETTLE/SAMPLE, keep partial sums
//   aborted        out  1   last scan was aborted, cleared on next start
// -----------------------------------------------------------------------------
module prm_result_scan #(
  parameter int unsigned SETTLE_CYC = 2,   // legal range 1..15
  parameter int unsigned NUM_WORDS  = 128  // fixed by the 4096-bit result
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        start,
  input  logic [31:0] result_imp,
  output logic [2:0]  sel1,
  output logic [7:0]  sel2,
  output logic        busy,
  output logic        done,
  output logic [12:0] hit_count,
  output logic        any_hit,
  output logic [11:0] first_hit_idx
`ifdef PRM_SCAN_ABORT_EN
  ,
  input  logic        abort,
  output logic        aborted
`endif
);

  localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYC - 1);
  localparam logic [6:0] LAST_WORD     = 7'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_FINISH
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [6:0]  r_w;
  logic [3:0]  r_settle;
  logic        r_busy;
  logic        r_done;
  logic [12:0] r_hit_count;
  logic        r_any_hit;
  logic [11:0] r_first_hit_idx;

  logic        w_accept;
  logic        w_abort;
  logic [5:0]  w_pop;
  logic [4:0]  w_low;

`ifdef PRM_SCAN_ABORT_EN
  logic        r_aborted;

  // abort only takes effect while a word is being settled or sampled
  assign w_abort = abort && ((r_state == S_SETTLE) || (r_state == S_SAMPLE));
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && start;

  // ---------------------------------------------------------------------------
  // Combinational popcount and lowest-set-bit encoder on the sampled word
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      w_pop = w_pop + 6'(result_imp[i]);
    end
  end

  // Scan from the top bit downwards so the last match is the lowest set bit.
  always_comb begin
    w_low = '0;
    for (int unsigned i = 32; i > 0; i--) begin
      if (result_imp[i-1]) begin
        w_low = 5'(i - 1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (w_abort) begin
          w_state_nxt = S_FINISH;
        end else if (r_settle == '0) begin
          w_state_nxt = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (w_abort || (r_w == LAST_WORD)) begin
          w_state_nxt = S_FINISH;
        end else begin
          w_state_nxt = S_SETTLE;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: word counter, settle counter, summary registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      r_w             <= '0;
      r_settle        <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_hit_count     <= '0;
      r_any_hit       <= 1'b0;
      r_first_hit_idx <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_w             <= '0;
            r_settle        <= SETTLE_RELOAD;
            r_busy          <= 1'b1;
            r_hit_count     <= '0;
            r_any_hit       <= 1'b0;
            r_first_hit_idx <= '0;
          end
        end
        S_SETTLE: begin
          if (w_abort) begin
            r_busy <= 1'b0;
          end else if (r_settle != '0) begin
            r_settle <= r_settle - 4'd1;
          end
        end
        S_SAMPLE: begin
          if (w_abort) begin
            r_busy <= 1'b0;
          end else begin
            r_hit_count <= r_hit_count + 13'(w_pop);
            if (!r_any_hit && (result_imp != '0)) begin
              r_any_hit       <= 1'b1;
              r_first_hit_idx <= {r_w, w_low};
            end
            // busy drops as FINISH is entered; done follows one cycle later
            if (r_w == LAST_WORD) begin
              r_busy <= 1'b0;
            end else begin
              r_w      <= r_w + 7'd1;
              r_settle <= SETTLE_RELOAD;
            end
          end
        end
        S_FINISH: begin
          r_done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef PRM_SCAN_ABORT_EN
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      r_aborted <= 1'b0;
    end else if (w_accept) begin
      r_aborted <= 1'b0;
    end else if (w_abort) begin
      r_aborted <= 1'b1;
    end
  end

  assign aborted = r_aborted;
`endif

  // ---------------------------------------------------------------------------
  // Outputs (all driven straight from registers)
  // ---------------------------------------------------------------------------
  assign sel1          = r_w[6:4];
  assign sel2          = {4'b0000, r_w[3:0]};
  assign busy          = r_busy;
  assign done          = r_done;
  assign hit_count     = r_hit_count;
  assign any_hit       = r_any_hit;
  assign first_hit_idx = r_first_hit_idx;

endmodule

// File: tb/tb_prm_result_scan.sv
// -----------------------------------------------------------------------------
// tb_prm_result_scan
//
// Self-checking bench for prm_result_scan. A 128-word array stands in for the
// upstream edge-check stage and is read through sel1/sel2. The expected
// summary comes from walking the 4096 bits of that array directly.
// -----------------------------------------------------------------------------
module tb_prm_result_scan;

  localparam int SETTLE   = 2;
  localparam int PER_WORD = SETTLE + 1;
  localparam int SCAN_LAT = 128 * PER_WORD + 1;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic        start;
  logic [31:0] result_imp;
  logic [2:0]  sel1;
  logic [7:0]  sel2;
  logic        busy;
  logic        done;
  logic [12:0] hit_count;
  logic        any_hit;
  logic [11:0] first_hit_idx;
`ifdef PRM_SCAN_ABORT_EN
  logic        abort;
  logic        aborted;
`endif

  logic [31:0] mem [128];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  assign result_imp = mem[{sel1, sel2[3:0]}];

  prm_result_scan #(.SETTLE_CYC(SETTLE)) dut (
    .CLK           (CLK),
    .RST_n         (RST_n),
    .start         (start),
    .result_imp    (result_imp),
    .sel1          (sel1),
    .sel2          (sel2),
    .busy          (busy),
    .done          (done),
    .hit_count     (hit_count),
    .any_hit       (any_hit),
    .first_hit_idx (first_hit_idx)
`ifdef PRM_SCAN_ABORT_EN
    ,
    .abort         (abort),
    .aborted       (aborted)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: count set bits over the first nwords words.
  function automatic int model_pop(input int nwords);
    int c = 0;
    for (int g = 0; g < nwords * 32; g++) begin
      if (mem[g / 32][g % 32]) c++;
    end
    return c;
  endfunction

  // Reference: lowest global set-bit index within the first nwords, -1 if none.
  function automatic int model_first(input int nwords);
    for (int g = 0; g < nwords * 32; g++) begin
      if (mem[g / 32][g % 32]) return g;
    end
    return -1;
  endfunction

  // Starts a scan and follows it until done. Cycle numbers count clock edges
  // after the edge that accepts start (that edge is cycle 0). pulse_cyc and
  // abort_cyc name the edge at which an extra start or abort is sampled
  // (-1 = never).
  task automatic do_scan(input int pulse_cyc, input int abort_cyc,
                         output int done_cyc, output int busy_n,
                         output int sel_bad, output logic busy_at_done);
    int   cyc;
    logic seen;
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1;
    start        = 1'b0;
    cyc          = 0;
    busy_n       = 0;
    sel_bad      = 0;
    seen         = 1'b0;
    done_cyc     = -1;
    busy_at_done = 1'bx;
    if (busy) begin
      busy_n++;
      if (int'({sel1, sel2[3:0]}) != cyc / PER_WORD || sel2[7:4] != 4'd0) sel_bad++;
    end
    while (!seen && cyc < 3000) begin
      start = (cyc + 1 == pulse_cyc);
`ifdef PRM_SCAN_ABORT_EN
      abort = (cyc + 1 == abort_cyc);
`endif
      @(posedge CLK);
      #1;
      cyc++;
      if (busy) begin
        busy_n++;
        if (int'({sel1, sel2[3:0]}) != cyc / PER_WORD || sel2[7:4] != 4'd0) sel_bad++;
      end
      if (done) begin
        seen         = 1'b1;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
    end
    start = 1'b0;
`ifdef PRM_SCAN_ABORT_EN
    abort = 1'b0;
`endif
    if (abort_cyc < 0 && pulse_cyc < -1) $display("unused");
  endtask

  // Full scan with summary checks against the model.
  task automatic full_scan(input string tag, input int pulse_cyc);
    int   dc, bn, sb, ef;
    logic bad;
    do_scan(pulse_cyc, -1, dc, bn, sb, bad);
    ef = model_first(128);
    check({tag, "_done_cyc"}, dc, SCAN_LAT);
    check({tag, "_busy_cycles"}, bn, SCAN_LAT - 1);
    check({tag, "_sel_seq"}, sb, 0);
    check({tag, "_busy_at_done"}, {31'd0, bad}, 0);
    check({tag, "_hit_count"}, hit_count, model_pop(128));
    check({tag, "_any_hit"}, any_hit, (ef >= 0) ? 1 : 0);
    check({tag, "_first_idx"}, first_hit_idx, (ef >= 0) ? ef : 0);
`ifdef PRM_SCAN_ABORT_EN
    check({tag, "_aborted"}, aborted, 0);
`endif
  endtask

  initial begin
    int cyc;
    int done_seen;

    RST_n = 1'b0;
    start = 1'b0;
`ifdef PRM_SCAN_ABORT_EN
    abort = 1'b0;
`endif
    foreach (mem[i]) mem[i] = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_any_hit", any_hit, 0);
    check("rst_first_idx", first_hit_idx, 0);
    check("rst_sel", {sel1, sel2}, 0);
    @(negedge CLK);
    RST_n = 1'b1;
    repeat (2) @(posedge CLK);

    // All-zero data.
    full_scan("zero", -1);

    // Single bit: word 37 bit 5 -> index 1189.
    mem[37] = 32'h0000_0020;
    full_scan("single", -1);
    check("single_idx_abs", first_hit_idx, 1189);

    // All ones, with a stray start mid-scan.
    foreach (mem[i]) mem[i] = '1;
    full_scan("ones_midstart", 150);
    check("ones_count_abs", hit_count, 4096);

    // Summary holds while idle.
    repeat (5) @(posedge CLK);
    #1;
    check("hold_hit_count", hit_count, 4096);

    // Words 3 and 100 with both end bits set.
    foreach (mem[i]) mem[i] = '0;
    mem[3]   = 32'h8000_0001;
    mem[100] = 32'h8000_0001;
    full_scan("two_words", -1);
    check("two_words_idx_abs", first_hit_idx, 96);

    // Start in the FINISH cycle (sampled at edge SCAN_LAT) must be ignored.
    full_scan("start_in_finish", SCAN_LAT);

    // Random sparse patterns.
    for (int t = 0; t < 3; t++) begin
      foreach (mem[i]) mem[i] = ($urandom_range(0, 9) == 0) ? $urandom : 32'd0;
      full_scan("random", -1);
    end

    // Reset asserted at edge 200 of a scan.
    foreach (mem[i]) mem[i] = '1;
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    cyc   = 0;
    while (cyc < 199) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    RST_n = 1'b0;
    @(posedge CLK);
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_hit_count", hit_count, 0);
    check("midrst_any_hit", any_hit, 0);
    check("midrst_first_idx", first_hit_idx, 0);
    check("midrst_sel", {sel1, sel2}, 0);
    RST_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge CLK);
      #1;
      if (done || busy) done_seen++;
    end
    check("midrst_no_done", done_seen, 0);
    foreach (mem[i]) mem[i] = $urandom;
    full_scan("after_rst", -1);

`ifdef PRM_SCAN_ABORT_EN
    // Abort sampled during the first SETTLE cycle of word 10.
    begin
      int   dc, bn, sb, ab_cyc, nacc;
      logic bad;
      foreach (mem[i]) mem[i] = (i < 10) ? 32'h0000_000F : 32'hFFFF_FFFF;
      ab_cyc = 10 * PER_WORD + 1;
      nacc   = 0;
      for (int w = 0; w < 128; w++) if (w * PER_WORD + PER_WORD < ab_cyc) nacc++;
      do_scan(-1, ab_cyc, dc, bn, sb, bad);
      check("abort_done_cyc", dc, ab_cyc + 1);
      check("abort_aborted", aborted, 1);
      check("abort_hit_count", hit_count, model_pop(nacc));
      check("abort_hit_count_abs", hit_count, 40);
      check("abort_first_idx", first_hit_idx, 0);
      check("abort_busy_at_done", {31'd0, bad}, 0);
      full_scan("post_abort", -1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prm_result_scan.md
Name: prm_result_scan

Overview:
Downstream consumer of the edge-check stage's windowed readout (sel1/sel2 select, 32-bit result_imp return). On a start pulse it sweeps all 128 result words (4096 edge bits) and accumulates:
- a population count of set edge bits;
- the index of the first set bit;
- an any-hit flag.
It then pulses done and holds the summary for the control/host side.

Parameters:
- SETTLE_CYC, 2, cycles the select outputs are held stable before result_imp is sampled; legal range 1..15; covers the combinational 4096-to-32 mux path.
- NUM_WORDS, 128, number of 32-bit words swept; fixed for the 4096-bit result; not to be overridden.

Ports:
- CLK  in  1  clock
- RST_n  in  1  reset, synchronous, active-low
- start  in  1  scan request; single-cycle pulse or level
- result_imp  in  32  selected result word from the upstream edge-check stage
- sel1  out  3  bank select, word index [6:4]
- sel2  out  8  word-in-bank select, {4'b0, word index [3:0]}
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the scan completes
- hit_count  out  13  number of set bits, 0..4096
- any_hit  out  1  at least one set bit seen
- first_hit_idx  out  12  global index of the lowest set bit, word*32+bit; 0 when any_hit=0

Behaviour:
- Reset values: all outputs 0, state IDLE, word counter w=0, settle counter 0. All outputs are registered.
- FSM states: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - start=1 is accepted.
  - On acceptance: w<=0, hit_count<=0, any_hit<=0, first_hit_idx<=0, settle counter<=SETTLE_CYC-1, state->SETTLE, busy<=1.
- SETTLE:
  - sel1/sel2 are driven from w and stay stable.
  - Counter decrements each cycle; at 0 the state moves to SAMPLE.
  - SETTLE lasts exactly SETTLE_CYC cycles.
- SAMPLE (1 cycle):
  - hit_count += popcount(result_imp).
  - If any_hit=0 and result_imp!=0: first_hit_idx<={w, index of lowest set bit of result_imp} and any_hit<=1.
  - If w==NUM_WORDS-1, state->FINISH; otherwise w<=w+1, settle counter reloaded, state->SETTLE.
- FINISH (1 cycle): done=1, busy=0, state->IDLE.
- Summary outputs hold their values until the next accepted start.
- Latency: done goes high 128*(SETTLE_CYC+1)+1 cycles after the start-accept edge. With the default SETTLE_CYC=2 this is 385 cycles.
- Boundary conditions:
  - start while busy: ignored, no restart.
  - start high in the FINISH cycle: ignored. A start in the following IDLE cycle is accepted.
  - Word counter: 7 bits with no wrap; the scan ends at w=127.
  - hit_count width: 13 bits, so the all-ones value 4096 does not overflow.
  - sel2[7:4]: always 0.
  - Reset asserted mid-scan: scan aborts in that cycle. All outputs return to reset values and no done pulse is produced.
- Popcount and the lowest-set-bit priority encoder are combinational within the SAMPLE cycle and are not pipelined.

Optional Feature:
PRM_SCAN_ABORT_EN
- Defined: adds two ports.
  - abort, input, 1 bit.
  - aborted, output, 1 bit, reset 0.
  - abort=1 in SETTLE or SAMPLE: the current word is not accumulated, state->FINISH, done pulses next cycle, aborted<=1.
  - Partial hit_count and first_hit_idx are held.
  - aborted clears on the next accepted start.
  - abort in IDLE or FINISH has no effect.
- Undefined: neither port exists; every accepted scan runs all 128 words.

Test Plan:
- All-zero result, default parameters: start -> done exactly 385 cycles after the accept edge; hit_count=0, any_hit=0, first_hit_idx=0; busy high for 384 cycles.
- Only bit 5 of word 37 set (sel1=2, sel2=5): first_hit_idx=1189, hit_count=1, any_hit=1. Check that sel1/sel2 are stable throughout every SETTLE window.
- All-ones model: hit_count=4096, first_hit_idx=0. Then pulse start mid-scan: no restart, and done still arrives at cycle 385.
- Words 3 and 100 both 0x8000_0001: hit_count=4, first_hit_idx=96.
- RST_n low at cycle 200 of a scan: outputs zero on the next edge, no done pulse. A new start then gives a full 385-cycle scan.
- With PRM_SCAN_ABORT_EN, abort at word 10 with words 0..9 each 0x0000_000F: aborted=1, hit_count=40, done one cycle after abort.
